// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        VALID = 2'd3
    } fetch_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int FETCH_LATENCY  = 6;
    localparam int INST_W         = 32;

    // Counter value of the final byte read within a word.
    function automatic logic [1:0] last_byte_idx();
        return 2'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: four byte reads from a synchronous byte ROM, assembled
// big-endian into one instruction word and handed over with valid/ready.
module inst_fetch_ctrl
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_ready,
    input  logic              flush,
    output logic              inst_valid,
    output logic [INST_W-1:0] instruction,
    input  logic              inst_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              busy
);

    fetch_state_e      state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] base;
    logic [INST_W-1:0] word;
    logic              rd_en_q;
    logic              accept;

    // Only the aligned in-range PC bits select a word; the rest alias.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[31:ADDR_W], fetch_pc[1:0]};

    assign fetch_ready = !flush && (state == IDLE || (state == VALID && inst_ready));
    assign accept      = fetch_req && fetch_ready;

    assign mem_rd_en   = (state == READ);
    assign mem_addr    = (state == READ) ? base + ADDR_W'(cnt) : base;
    assign inst_valid  = (state == VALID);
    assign instruction = word;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            base    <= '0;
            word    <= '0;
            rd_en_q <= 1'b0;
        end else if (flush) begin
            // Clearing rd_en_q drops the byte still in flight from the ROM.
            state   <= IDLE;
            cnt     <= 2'd0;
            rd_en_q <= 1'b0;
        end else begin
            rd_en_q <= mem_rd_en;
            if (rd_en_q)
                word <= {word[INST_W-9:0], mem_rd_data};

            if (accept) begin
                base  <= {fetch_pc[ADDR_W-1:2], 2'b00};
                cnt   <= 2'd0;
                word  <= '0;
                state <= READ;
            end else begin
                case (state)
                    READ: begin
                        cnt <= cnt + 2'd1;
                        if (cnt == last_byte_idx())
                            state <= DRAIN;
                    end
                    DRAIN:   state <= VALID;
                    VALID:   if (inst_ready) state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a behavioural synchronous byte ROM
// and a scoreboard that checks every completed instruction handshake.
module tb_inst_fetch_ctrl;
    import cpu_fetch_pkg::*;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic [31:0]       fetch_pc;
    logic              fetch_ready;
    logic              flush;
    logic              inst_valid;
    logic [31:0]       instruction;
    logic              inst_ready;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    logic [7:0] rom [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    // Registered-read byte memory, data one cycle after the strobe.
    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= rom[mem_addr];

    inst_fetch_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .flush(flush), .inst_valid(inst_valid),
        .instruction(instruction), .inst_ready(inst_ready),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got %08h expected none", instruction);
            end else begin
                chk("sb_word", instruction, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic handshake();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    // Present a request; it must be accepted in this cycle.
    task automatic issue(input logic [31:0] pc, input logic [31:0] exp_word, input string name);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        @(negedge clk);
        chk(name, {31'd0, fetch_ready}, 32'd1);
        exp_q.push_back(exp_word);
        tick();
        fetch_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'hEE;
        rom[16'h10] = 8'h12; rom[16'h11] = 8'h34; rom[16'h12] = 8'h56; rom[16'h13] = 8'h78;
        rom[16'h14] = 8'h9A; rom[16'h15] = 8'hBC; rom[16'h16] = 8'hDE; rom[16'h17] = 8'hF0;
        rom[16'h18] = 8'h11; rom[16'h19] = 8'h22; rom[16'h1A] = 8'h33; rom[16'h1B] = 8'h44;
        rom[16'h20] = 8'hCA; rom[16'h21] = 8'hFE; rom[16'h22] = 8'hBA; rom[16'h23] = 8'hBE;

        rst = 1'b1; fetch_req = 1'b0; fetch_pc = '0; flush = 1'b0; inst_ready = 1'b0;
        #12;
        chk("rst_valid",  {31'd0, inst_valid},  32'd0);
        chk("rst_instr",  instruction,          32'd0);
        chk("rst_rd_en",  {31'd0, mem_rd_en},   32'd0);
        chk("rst_addr",   32'(mem_addr),        32'd0);
        chk("rst_busy",   {31'd0, busy},        32'd0);
        chk("rst_ready",  {31'd0, fetch_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // Single fetch: address sequence and exact latency.
        issue(32'h10, 32'h12345678, "single_accept");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("single_rd_en", {31'd0, mem_rd_en}, 32'd1);
            chk("single_addr",  32'(mem_addr), 32'h10 + k);
            tick();
        end
        chk("single_not_yet", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("single_lat", {31'd0, inst_valid}, 32'd1);
        handshake();

        // Aliased, misaligned PC maps onto the same word.
        issue(32'h0001_0013, 32'h12345678, "alias_accept");
        @(negedge clk);
        chk("alias_addr", 32'(mem_addr), 32'h10);
        wait_valid("alias_valid");
        handshake();

        // Backpressure, then back-to-back accept from VALID.
        issue(32'h10, 32'h12345678, "bp_accept");
        wait_valid("bp_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_stable", instruction, 32'h12345678);
            chk("bp_not_ready", {31'd0, fetch_ready}, 32'd0);
            tick();
        end
        inst_ready = 1'b1;
        issue(32'h14, 32'h9ABCDEF0, "b2b_accept");
        inst_ready = 1'b0;
        for (int k = 1; k < FETCH_LATENCY - 1; k++) tick();
        chk("b2b_not_yet", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("b2b_lat", {31'd0, inst_valid}, 32'd1);
        handshake();

        // Flush in cycle 3 of a fetch; next fetch carries no stale bytes.
        issue(32'h18, 32'h0, "flush_accept");
        void'(exp_q.pop_back());
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy",  {31'd0, busy},      32'd0);
        chk("flush_rd_en", {31'd0, mem_rd_en}, 32'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                if (inst_valid) seen++;
                tick();
            end
            chk("flush_no_valid", 32'(seen), 32'd0);
        end
        issue(32'h20, 32'hCAFEBABE, "post_flush_accept");
        wait_valid("post_flush_valid");
        handshake();

        // Flush coinciding with a request in IDLE blocks it for one cycle.
        flush = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h10;
        @(negedge clk);
        chk("flush_req_ready", {31'd0, fetch_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_req_idle", {31'd0, mem_rd_en}, 32'd0);
        issue(32'h10, 32'h12345678, "held_req_accept");
        chk("held_req_addr", {31'd0, mem_rd_en} << 16 | 32'(mem_addr), 32'h0001_0010);
        wait_valid("held_req_valid");
        handshake();

        // Reset mid-READ.
        issue(32'h14, 32'h0, "rst_mid_accept");
        void'(exp_q.pop_back());
        tick();
        chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, inst_valid},  32'd0);
        chk("rst_mid_rd_en", {31'd0, mem_rd_en},   32'd0);
        chk("rst_mid_busy",  {31'd0, busy},        32'd0);
        chk("rst_mid_ready", {31'd0, fetch_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
